// File: rtl/pid_scheduler.sv
// Shares one PID datapath across NUM_MOTORS channels: each control tick sweeps the
// enabled channels in index order and keeps a registered duty per channel.
module pid_scheduler #(
  parameter int NUM_MOTORS = 4,
  parameter int CH_W       = 2,
  parameter int TICK_DIV   = 1000,
  parameter int TIMEOUT    = 64
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [NUM_MOTORS-1:0]      enable,
  input  logic [24*NUM_MOTORS-1:0]   setpoint_flat,
  input  logic [24*NUM_MOTORS-1:0]   state_flat,
  output logic                       pid_start,
  output logic [CH_W-1:0]            pid_channel,
  output logic [23:0]                pid_setpoint,
  output logic [23:0]                pid_state,
  input  logic                       pid_done,
  input  logic [23:0]                pid_duty,
  output logic [24*NUM_MOTORS-1:0]   duty_flat,
  output logic [NUM_MOTORS-1:0]      duty_update,
  output logic                       busy,
  output logic                       overrun,
  output logic [NUM_MOTORS-1:0]      timeout_err,
  input  logic                       clear_err
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [CH_W:0]   PTR_END   = (CH_W + 1)'(NUM_MOTORS);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT, STORE} state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [CH_W:0]   ptr;
  logic [CH_W-1:0] ch;
  logic [WW-1:0]   wait_cnt;
  logic [23:0]     duty   [NUM_MOTORS];
  logic [23:0]     sp_arr [NUM_MOTORS];
  logic [23:0]     st_arr [NUM_MOTORS];

  assign tick = (tick_cnt == TICK_LAST);
  assign ch   = ptr[CH_W-1:0];
  assign busy = (state != IDLE);

  always_comb begin
    sp_arr    = '{default: '0};
    st_arr    = '{default: '0};
    duty_flat = '0;
    for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
      sp_arr[i]               = setpoint_flat[24*i +: 24];
      st_arr[i]               = state_flat[24*i +: 24];
      duty_flat[24*i +: 24]   = duty[i];
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      ptr          <= '0;
      wait_cnt     <= '0;
      duty         <= '{default: '0};
      pid_start    <= 1'b0;
      pid_channel  <= '0;
      pid_setpoint <= '0;
      pid_state    <= '0;
      duty_update  <= '0;
      overrun      <= 1'b0;
      timeout_err  <= '0;
    end else begin
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      pid_start   <= 1'b0;
      duty_update <= '0;

      // Clear first so a coincident set below takes precedence.
      if (clear_err) begin
        overrun     <= 1'b0;
        timeout_err <= '0;
      end
      if (tick && busy) overrun <= 1'b1;

      unique case (state)
        IDLE: begin
          if (tick && (enable != '0)) begin
            ptr   <= '0;
            state <= SELECT;
          end
        end
        SELECT: begin
          if (ptr == PTR_END) begin
            state <= IDLE;
          end else if (!enable[ch]) begin
            duty[ch] <= '0;
            ptr      <= ptr + 1'b1;
          end else begin
            // Operands and the start pulse are registered on entry so the
            // datapath sees them for the whole ISSUE cycle.
            pid_channel  <= ch;
            pid_setpoint <= sp_arr[ch];
            pid_state    <= st_arr[ch];
            pid_start    <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (pid_done) begin
            duty[ch]        <= pid_duty;
            duty_update[ch] <= 1'b1;
            state           <= STORE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err[ch] <= 1'b1;
            duty[ch]        <= '0;
            duty_update[ch] <= 1'b1;
            ptr             <= ptr + 1'b1;
            state           <= SELECT;
          end
        end
        STORE: begin
          ptr   <= ptr + 1'b1;
          state <= SELECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pid_scheduler.md
Name: pid_scheduler

Overview:
- Time-multiplexes one shared PID datapath across NUM_MOTORS motor channels.
- A free-running divider generates the control tick. On each tick the block sweeps the enabled channels in ascending index order:
  - issues each channel's setpoint/state to the datapath;
  - waits for its done pulse;
  - stores the returned duty in a per-channel register that drives the PWM generators.
- Sits between the motor register bank / encoder front-ends and the PWM outputs.

Parameters:
- NUM_MOTORS, 4, number of channels served (1..16)
- CH_W, 2, channel index width, ceil(log2(NUM_MOTORS)), min 1
- TICK_DIV, 1000, control period in CLK cycles (>= NUM_MOTORS*(TIMEOUT+4))
- TIMEOUT, 64, max cycles waited in WAIT for pid_done

Ports:
- CLK  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous active-low reset; 0 = reset asserted, release synchronous to CLK
- enable  input  NUM_MOTORS  per-channel enable mask
- setpoint_flat  input  24*NUM_MOTORS  signed setpoints, channel i at bits [24i+23:24i]
- state_flat  input  24*NUM_MOTORS  signed measured positions, same packing
- pid_start  output  1  one-cycle request pulse to shared datapath
- pid_channel  output  CH_W  channel being served
- pid_setpoint  output  24  signed setpoint of served channel
- pid_state  output  24  signed state of served channel
- pid_done  input  1  one-cycle completion pulse from datapath
- pid_duty  input  24  signed duty result, valid when pid_done=1
- duty_flat  output  24*NUM_MOTORS  signed registered duty per channel
- duty_update  output  NUM_MOTORS  one-cycle pulse on bit i when duty i is written
- busy  output  1  high whenever FSM is not IDLE
- overrun  output  1  sticky: tick arrived while busy
- timeout_err  output  NUM_MOTORS  sticky per channel: datapath failed to answer
- clear_err  input  1  synchronous clear of overrun and timeout_err

Behaviour:
- Reset values (reset=0): all outputs 0, FSM IDLE, tick counter 0, channel pointer 0.
- Tick counter:
  - counts 0..TICK_DIV-1 and wraps to 0;
  - tick is asserted for one cycle when the count equals TICK_DIV-1;
  - runs regardless of FSM state.
- States: IDLE, SELECT, ISSUE, WAIT, STORE.
- IDLE:
  - on tick, go to SELECT with pointer=0;
  - if enable==0, stay IDLE (no sweep).
- SELECT:
  - if enable[pointer]=0: force duty[pointer]=0 (no duty_update pulse) and advance the pointer;
  - once the pointer passes NUM_MOTORS-1, return to IDLE;
  - otherwise go to ISSUE;
  - evaluates one channel per cycle.
- ISSUE:
  - latch setpoint/state of pointer into pid_setpoint/pid_state;
  - drive pid_channel=pointer and assert pid_start for exactly one cycle;
  - go to WAIT and clear the wait counter.
- pid_channel, pid_setpoint and pid_state hold stable from the ISSUE cycle until leaving STORE. Inputs that change mid-service are not seen until the next tick.
- WAIT:
  - on pid_done=1, capture pid_duty and go to STORE;
  - the wait counter increments each cycle;
  - if it reaches TIMEOUT without pid_done: set timeout_err[pointer], write duty[pointer]=0, pulse duty_update[pointer], advance the pointer, go to SELECT.
  - pid_done in the same cycle as the counter reaching TIMEOUT counts as success.
- STORE:
  - write the captured duty to duty[pointer] and pulse duty_update[pointer] in the same cycle;
  - advance the pointer, go to SELECT.
- pid_done received in any state other than WAIT is ignored.
- Latency: tick at cycle T gives pid_start for the first enabled channel 0 at T+2. Duty is written on the cycle after pid_done.
- Overrun: a tick while busy=1 sets overrun and is dropped; the current sweep continues.
- Error clearing:
  - clear_err clears overrun and timeout_err;
  - a set condition in the same cycle as clear_err wins (flag stays 1).
- Disable mid-sweep: enable is sampled only in SELECT. A channel already in ISSUE/WAIT completes normally.
- Duty values pass through unmodified (no saturation here; limiting is done in the datapath).
- Reset mid-sweep: immediately returns to IDLE with all duties 0; any pending pid_done is ignored.

Test Plan:
- enable=4'b1111, datapath answers 5 cycles after pid_start with duty=100*(ch+1) -> pid_start at T+2 for ch0; duty_flat = {400,300,200,100}; four duty_update pulses in order 0..3; busy falls before the next tick.
- enable=4'b0101 -> only ch0 and ch2 issued; duty1 and duty3 read 0; no duty_update on bits 1 and 3.
- Datapath never answers ch2 -> after 64 WAIT cycles timeout_err=4'b0100 and duty2=0; ch3 is still served; clear_err returns timeout_err to 0.
- TICK_DIV=20 with a 10-cycle datapath latency and 4 channels -> overrun=1; sweep completes all 4 channels; next sweep starts on the following tick.
- Change state_flat ch1 while ch1 is in WAIT -> pid_state unchanged until STORE; the new value is used on the next tick.
- Assert reset=0 during WAIT of ch1 -> all outputs 0 immediately; a late pid_done after release is ignored; normal sweep resumes at the next tick.
